raw_regfile_mp: RTL and testbench
=================================

Name: raw_regfile_mp

Overview:
- Parametrised successor of the single-write, dual-read forwarding register file used in the decode stage.
- Provides NUM_READ combinational read ports and NUM_WRITE synchronous write ports.
- Register 0 is hardwired to zero; same-cycle read-after-write forwarding and write-port priority are resolved inside the block.
- Adds a per-register pending-write scoreboard: issue marks a destination busy, writeback clears it, and each read port reports its operand's busy status to the hazard unit.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; power of two, >= 2; AW = clog2(NUM_REGS) is a derived localparam.
- NUM_READ, 2, number of read ports; >= 1.
- NUM_WRITE, 2, number of write ports; >= 1; a higher index has higher priority.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rs_addr  in  NUM_READ*AW  read addresses; port i occupies bits [i*AW +: AW].
- rs_data  out  NUM_READ*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rs_busy  out  NUM_READ  1 means the operand has an outstanding producer.
- wr_en  in  NUM_WRITE  per-port write enable.
- wr_addr  in  NUM_WRITE*AW  write addresses.
- wr_data  in  NUM_WRITE*XLEN  write data.
- issue_valid  in  1  marks issue_addr busy at the next edge.
- issue_addr  in  AW  destination register of the issued instruction.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (port reset). All state updates occur on the rising edge of clk.
- Reset:
  - When reset is high at an edge, all NUM_REGS registers are cleared to 0 and all busy bits to 0.
  - wr_en and issue_valid are ignored in that cycle.
  - While reset is high, rs_data is forced to 0 and rs_busy to 0 combinationally.
  - Asserting reset mid-operation discards pending writes and issues in that cycle; there is no other recovery state.
- Register 0:
  - Writes to address 0 are dropped; issue to address 0 is dropped.
  - Reads of address 0 return 0 and rs_busy 0, regardless of forwarding.
- Write:
  - Effective write k = wr_en[k] && wr_addr_k != 0.
  - At the edge, reg[wr_addr_k] <= wr_data_k.
  - If several effective writes target the same address, the highest k wins; lower-index data is discarded.
- Read (combinational, zero latency):
  - If any effective write k matches rs_addr_i, rs_data_i = wr_data of the highest-index matching k (forwarding).
  - Otherwise rs_data_i = reg[rs_addr_i].
  - Address compares use the full AW bits.
- Scoreboard (busy[NUM_REGS], busy[0] constant 0):
  - At an edge, an effective write to address a clears busy[a].
  - At the same edge, issue_valid with issue_addr = a != 0 sets busy[a].
  - If issue and write target the same address in the same cycle, the set wins and busy stays 1 (a new producer is pending).
  - rs_busy_i = busy[rs_addr_i], except it is 0 when an effective write to rs_addr_i occurs in the same cycle (the value is forwarded).
  - An issue in the current cycle does not affect rs_busy combinationally; it is visible from the next cycle.
  - Writes to non-busy registers are legal and simply update data.
  - Duplicate issue to an already-busy register keeps it at 1; there is no counting.
- No handshake back-pressure: every write and issue is accepted in the cycle it is presented.

Optional Feature:
- Macro: RAW_BYPASS_EN.
- Defined: same-cycle forwarding as above, for both rs_data and rs_busy.
- Undefined:
  - rs_data_i = reg[rs_addr_i] and rs_busy_i = busy[rs_addr_i] (read-before-write); new data is visible the cycle after the write.
  - The forwarding compare/mux logic is removed.
  - Write priority, the scoreboard, register 0 and reset behaviour are unchanged.

Test Plan:
- Reset, then read all addresses on both ports -> rs_data = 0 and rs_busy = 0 for every address. With reset high, write reg 5 = 0xDEADBEEF, then release and read 5 -> 0x00000000.
- Write port 0 addr 3 = 0x12345678 while read port 1 addr 3 in the same cycle:
  - With RAW_BYPASS_EN -> rs_data1 = 0x12345678 in that cycle.
  - Without -> old value 0 that cycle, 0x12345678 the next cycle.
- Both write ports target addr 7 (port 0 = 0xAAAA0000, port 1 = 0x5555FFFF) -> same-cycle forwarded value and stored value are both 0x5555FFFF.
- Write addr 0 = 0xFFFFFFFF and issue to addr 0 -> read addr 0 gives 0, rs_busy 0.
- Issue addr 9; next cycle read 9 -> rs_busy = 1. Write 9 = 0x00000042:
  - Same cycle, with RAW_BYPASS_EN -> rs_busy = 0 and rs_data = 0x42.
  - Next cycle -> rs_busy 0.
- Issue addr 12 and write addr 12 = 0x1 in the same cycle -> next cycle rs_busy = 1 and rs_data = 0x1. Assert reset -> busy cleared and data 0.

Source files
------------

// File: rtl/raw_regfile_mp_if.sv
// Bundle of the register-file read, write and issue signals.
// Master drives addresses, writes and issues; slave returns read data and busy status.
interface raw_regfile_mp_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_READ  = 2,
    parameter int unsigned NUM_WRITE = 2
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [NUM_READ*AW-1:0]    rs_addr;
    logic [NUM_READ*XLEN-1:0]  rs_data;
    logic [NUM_READ-1:0]       rs_busy;
    logic [NUM_WRITE-1:0]      wr_en;
    logic [NUM_WRITE*AW-1:0]   wr_addr;
    logic [NUM_WRITE*XLEN-1:0] wr_data;
    logic                      issue_valid;
    logic [AW-1:0]             issue_addr;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, issue_valid, issue_addr,
        input  rs_data, rs_busy
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, issue_valid, issue_addr,
        output rs_data, rs_busy
    );
endinterface

// File: rtl/raw_regfile_mp.sv
// Multi-port register file with write priority, pending-write scoreboard and
// optional same-cycle read-after-write bypass (macro RAW_BYPASS_EN).
module raw_regfile_mp #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_READ  = 2,
    parameter int unsigned NUM_WRITE = 2
) (
    input logic             clk,
    input logic             reset,
    raw_regfile_mp_if.slave bus
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [NUM_WRITE-1:0] wr_eff;
    logic [AW-1:0]        wa [NUM_WRITE];
    logic [XLEN-1:0]      wd [NUM_WRITE];

    // Unpack write ports; writes to register 0 never take effect.
    for (genvar k = 0; k < NUM_WRITE; k++) begin : g_wr
        assign wa[k]     = bus.wr_addr[k*AW +: AW];
        assign wd[k]     = bus.wr_data[k*XLEN +: XLEN];
        assign wr_eff[k] = bus.wr_en[k] && (wa[k] != '0);
    end

    // Next state: ascending port order so the highest index wins; issue set beats write clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < NUM_WRITE; k++) begin
            if (wr_eff[k]) begin
                regs_d[wa[k]] = wd[k];
                busy_d[wa[k]] = 1'b0;
            end
        end
        if (bus.issue_valid && (bus.issue_addr != '0)) begin
            busy_d[bus.issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign ra = bus.rs_addr[i*AW +: AW];

        // Combinational read; forwarded write data also hides the stale busy bit.
        always_comb begin
            rd = regs_q[ra];
            rb = busy_q[ra];
`ifdef RAW_BYPASS_EN
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (wr_eff[k] && (wa[k] == ra)) begin
                    rd = wd[k];
                    rb = 1'b0;
                end
            end
`endif
            if (reset || (ra == '0)) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign bus.rs_data[i*XLEN +: XLEN] = rd;
        assign bus.rs_busy[i]              = rb;
    end
endmodule

// File: tb/tb_raw_regfile_mp.sv
// Directed bench for raw_regfile_mp; expected reads are queued when stimulus is
// driven and compared against the DUT at the following falling edge.
module tb_raw_regfile_mp;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NR   = 32;
    localparam int unsigned AW   = 5;
`ifdef RAW_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    logic clk;
    logic reset;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    raw_regfile_mp_if #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_READ(2), .NUM_WRITE(2)) bus ();

    raw_regfile_mp #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_READ(2), .NUM_WRITE(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.rs_addr     = '0;
        bus.wr_en       = '0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_addr  = '0;
    endtask

    task automatic rd(input int p, input int a);
        bus.rs_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int k, input int a, input logic [31:0] d);
        bus.wr_en[k]                = 1'b1;
        bus.wr_addr[k*AW +: AW]     = AW'(a);
        bus.wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic iss(input int a);
        bus.issue_valid = 1'b1;
        bus.issue_addr  = AW'(a);
    endtask

    task automatic expect_rd(input string tag, input int p, input logic [31:0] d, input logic b);
        exp_t e;
        e.tag = tag; e.port = p; e.data = d; e.busy = b;
        q.push_back(e);
    endtask

    // Compare queued expectations mid-cycle, then advance past the next rising edge.
    task automatic step();
        exp_t e;
        logic [31:0] od;
        logic        ob;
        @(negedge clk);
        while (q.size() > 0) begin
            e  = q.pop_front();
            od = bus.rs_data[e.port*XLEN +: XLEN];
            ob = bus.rs_busy[e.port];
            checks++;
            assert (od === e.data) else begin
                errors++;
                $error("FAIL %s data port%0d observed=%h expected=%h", e.tag, e.port, od, e.data);
            end
            checks++;
            assert (ob === e.busy) else begin
                errors++;
                $error("FAIL %s busy port%0d observed=%b expected=%b", e.tag, e.port, ob, e.busy);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();

        // Reset forces zero reads even with a write presented.
        wr(0, 5, 32'hDEADBEEF); iss(6); rd(0, 5); rd(1, 6);
        expect_rd("rst_fwd_zero", 0, 32'h0, 1'b0);
        expect_rd("rst_busy_zero", 1, 32'h0, 1'b0);
        step();
        idle(); reset = 1'b0;

        for (int a = 0; a < NR; a++) begin
            rd(0, a); rd(1, NR - 1 - a);
            expect_rd("reset_scan", 0, 32'h0, 1'b0);
            expect_rd("reset_scan", 1, 32'h0, 1'b0);
            step();
        end

        // Same-cycle read of a write from port 0.
        idle(); wr(0, 3, 32'h12345678); rd(1, 3);
        expect_rd("raw_same", 1, BYP ? 32'h12345678 : 32'h0, 1'b0);
        step();
        idle(); rd(1, 3);
        expect_rd("raw_next", 1, 32'h12345678, 1'b0);
        step();

        // Both ports hit the same address: port 1 wins.
        idle(); wr(0, 7, 32'hAAAA0000); wr(1, 7, 32'h5555FFFF); rd(0, 7);
        expect_rd("prio_same", 0, BYP ? 32'h5555FFFF : 32'h0, 1'b0);
        step();
        idle(); rd(0, 7); rd(1, 7);
        expect_rd("prio_store", 0, 32'h5555FFFF, 1'b0);
        expect_rd("prio_store", 1, 32'h5555FFFF, 1'b0);
        step();

        // Independent writes on both ports.
        idle(); wr(0, 20, 32'hA5A5_0020); wr(1, 21, 32'h5A5A_0021);
        step();
        idle(); rd(0, 20); rd(1, 21);
        expect_rd("dual_wr", 0, 32'hA5A5_0020, 1'b0);
        expect_rd("dual_wr", 1, 32'h5A5A_0021, 1'b0);
        step();

        // Register 0 ignores writes and issues.
        idle(); wr(1, 0, 32'hFFFFFFFF); iss(0); rd(0, 0);
        expect_rd("r0_same", 0, 32'h0, 1'b0);
        step();
        idle(); rd(0, 0); rd(1, 0);
        expect_rd("r0_next", 0, 32'h0, 1'b0);
        expect_rd("r0_next", 1, 32'h0, 1'b0);
        step();

        // Scoreboard set, bypassed clear, then cleared.
        idle(); iss(9); rd(0, 9);
        expect_rd("iss_not_comb", 0, 32'h0, 1'b0);
        step();
        idle(); rd(0, 9);
        expect_rd("busy_set", 0, 32'h0, 1'b1);
        step();
        idle(); wr(1, 9, 32'h00000042); rd(0, 9); rd(1, 9);
        expect_rd("wb_same", 0, BYP ? 32'h42 : 32'h0, BYP ? 1'b0 : 1'b1);
        expect_rd("wb_same", 1, BYP ? 32'h42 : 32'h0, BYP ? 1'b0 : 1'b1);
        step();
        idle(); rd(0, 9);
        expect_rd("wb_next", 0, 32'h42, 1'b0);
        step();

        // Duplicate issue does not count.
        idle(); iss(15); step();
        idle(); iss(15); step();
        idle(); wr(0, 15, 32'h0000_0F0F); step();
        idle(); rd(1, 15);
        expect_rd("dup_issue", 1, 32'h0000_0F0F, 1'b0);
        step();

        // Issue and write to the same register: set wins.
        idle(); iss(12); wr(0, 12, 32'h1); rd(0, 12);
        expect_rd("iss_wr_same", 0, BYP ? 32'h1 : 32'h0, 1'b0);
        step();
        idle(); rd(0, 12);
        expect_rd("iss_wins", 0, 32'h1, 1'b1);
        step();

        // Reset mid-operation clears data and busy, and drops the concurrent write.
        idle(); reset = 1'b1; rd(0, 12); rd(1, 13); wr(0, 13, 32'h13); iss(14);
        expect_rd("rst_mid", 0, 32'h0, 1'b0);
        expect_rd("rst_mid", 1, 32'h0, 1'b0);
        step();
        idle(); reset = 1'b0; rd(0, 12); rd(1, 13);
        expect_rd("post_rst", 0, 32'h0, 1'b0);
        expect_rd("post_rst", 1, 32'h0, 1'b0);
        step();
        idle(); rd(0, 14); rd(1, 20);
        expect_rd("post_rst_b", 0, 32'h0, 1'b0);
        expect_rd("post_rst_b", 1, 32'h0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
